// File: rtl/store_drain_buffer.sv
// Posted-write FIFO between the memory stage and data memory; loads probe it for forwarding or stall.
// Optional STORE_FWD_EN enables word-store forwarding; otherwise any matching load just stalls.
module store_drain_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_valid,
    input  logic [DATA_WIDTH-1:0]     push_addr,
    input  logic [DATA_WIDTH-1:0]     push_data,
    input  logic                      push_byte,
    output logic                      push_ready,
    input  logic                      mem_busy,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wd,
    output logic                      mem_byte,
    input  logic [DATA_WIDTH-1:0]     lookup_addr,
    output logic                      lookup_hit,
    output logic [DATA_WIDTH-1:0]     lookup_data,
    output logic                      lookup_conflict,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] WORD_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

    logic [DATA_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic                  r_byte [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic w_push;
    logic w_pop;
    logic w_found;

    assign empty      = (r_count == '0);
    assign push_ready = (r_count != CW'(DEPTH));
    assign count      = r_count;
    assign mem_we     = !empty && !mem_busy;
    assign mem_addr   = r_addr[r_head];
    assign mem_wd     = r_data[r_head];
    assign mem_byte   = r_byte[r_head];
    assign w_push     = push_valid && push_ready;
    assign w_pop      = mem_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_byte[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= push_addr;
                r_data[r_tail] <= push_data;
                r_byte[r_tail] <= push_byte;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef STORE_FWD_EN
    logic                  w_found_byte;
    logic [DATA_WIDTH-1:0] w_found_data;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_found      = 1'b0;
        w_found_byte = 1'b0;
        w_found_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) &&
                (((r_addr[r_head + PW'(i)] ^ lookup_addr) & WORD_MASK) == '0)) begin
                w_found      = 1'b1;
                w_found_byte = r_byte[r_head + PW'(i)];
                w_found_data = r_data[r_head + PW'(i)];
            end
        end
    end

    assign lookup_hit      = w_found && !w_found_byte;
    assign lookup_data     = lookup_hit ? w_found_data : '0;
    assign lookup_conflict = w_found && w_found_byte;
`else
    always_comb begin
        w_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) &&
                (((r_addr[r_head + PW'(i)] ^ lookup_addr) & WORD_MASK) == '0)) begin
                w_found = 1'b1;
            end
        end
    end

    assign lookup_hit      = 1'b0;
    assign lookup_data     = '0;
    assign lookup_conflict = w_found;
`endif

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer: expected memory writes are queued at push time and
// compared in order whenever the buffer drives a write.
module tb_store_drain_buffer;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_valid;
  logic [DW-1:0] push_addr;
  logic [DW-1:0] push_data;
  logic          push_byte;
  logic          push_ready;
  logic          mem_busy;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic          mem_byte;
  logic [DW-1:0] lookup_addr;
  logic          lookup_hit;
  logic [DW-1:0] lookup_data;
  logic          lookup_conflict;
  logic          empty;
  logic [2:0]    count;

  int n_pass = 0;
  int n_total = 0;
  logic [64:0] exp_q[$];

  always #5 clk = ~clk;

  store_drain_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data),
    .push_byte(push_byte), .push_ready(push_ready),
    .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_byte(mem_byte),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .lookup_conflict(lookup_conflict), .empty(empty), .count(count)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive a push request and record the write it must eventually produce.
  task automatic drive_push(input logic [DW-1:0] a, input logic [DW-1:0] d, input logic b,
                            input bit expect_accept);
    push_valid = 1'b1;
    push_addr  = a;
    push_data  = d;
    push_byte  = b;
    if (expect_accept) exp_q.push_back({b, a, d});
  endtask

  // One clock: scoreboard any write at the negedge, then advance past the next posedge.
  task automatic tick();
    logic [64:0] e;
    @(negedge clk);
    if (mem_we) begin
      chk("write_expected", 65'(exp_q.size() != 0), 65'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("drain_entry", {mem_byte, mem_addr, mem_wd}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_empty"}, 65'(empty), 65'd1);
    chk({tag, "_ready"}, 65'(push_ready), 65'd1);
    chk({tag, "_count"}, 65'(count), 65'd0);
    chk({tag, "_we"}, 65'(mem_we), 65'd0);
  endtask

  initial begin
    logic [DW-1:0] d;
    int guard;
    rst = 1'b1;
    push_valid = 1'b0;
    push_addr = '0;
    push_data = '0;
    push_byte = 1'b0;
    mem_busy = 1'b0;
    lookup_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check_idle("rst");
    chk("rst_addr", 65'(mem_addr), 65'd0);
    chk("rst_wd", 65'(mem_wd), 65'd0);
    chk("rst_byte", 65'(mem_byte), 65'd0);
    chk("rst_hit", 65'(lookup_hit), 65'd0);
    chk("rst_ldata", 65'(lookup_data), 65'd0);
    chk("rst_conf", 65'(lookup_conflict), 65'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("idle");
    end

    // Single word store: one-cycle latency, no bypass
    drive_push(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1);
    #1;
    chk("no_bypass_we", 65'(mem_we), 65'd0);
    tick();
    push_valid = 1'b0;
    #1;
    chk("lat_we", 65'(mem_we), 65'd1);
    chk("lat_addr", 65'(mem_addr), 65'h10);
    chk("lat_wd", 65'(mem_wd), 65'hDEAD_BEEF);
    tick();
    check_idle("after_one");

    // Fill while memory busy, fifth push ignored
    mem_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      drive_push(32'h100 + 32'(4 * i), d, 1'b0, 1'b1);
      tick();
    end
    push_valid = 1'b0;
    #1;
    chk("full_ready", 65'(push_ready), 65'd0);
    chk("full_count", 65'(count), 65'd4);
    chk("busy_we", 65'(mem_we), 65'd0);
    drive_push(32'h200, 32'h55, 1'b0, 1'b0);
    tick();
    push_valid = 1'b0;
    tick();
    chk("ignored_count", 65'(count), 65'd4);
    chk("busy_head", 65'(mem_addr), 65'h100);
    mem_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("burst_we", 65'(mem_we), 65'd1);
      tick();
    end
    check_idle("burst_done");
    drive_push(32'h300, $urandom, 1'b0, 1'b1);
    tick();
    push_valid = 1'b0;
    #1;
    chk("wrap_we", 65'(mem_we), 65'd1);
    tick();
    check_idle("wrap_done");

    // Full buffer with a held push while draining
    mem_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_push(32'h400 + 32'(4 * i), $urandom, 1'b0, 1'b1);
      tick();
    end
    mem_busy = 1'b0;
    drive_push(32'h500, 32'h5A5A_0001, 1'b0, 1'b0);
    #1;
    chk("held_ready0", 65'(push_ready), 65'd0);
    chk("held_we", 65'(mem_we), 65'd1);
    tick();
    chk("held_count3", 65'(count), 65'd3);
    chk("held_ready1", 65'(push_ready), 65'd1);
    exp_q.push_back({1'b0, 32'h500, 32'h5A5A_0001});
    tick();
    push_valid = 1'b0;
    chk("held_count_acc", 65'(count), 65'd3);
    guard = 0;
    while (!empty && guard < 10) begin
      tick();
      guard++;
    end
    chk("drain_bound", 65'(empty), 65'd1);
    chk("queue_empty", 65'(exp_q.size()), 65'd0);

    // Lookup: two word stores to the same word, then a byte store
    mem_busy = 1'b1;
    drive_push(32'h20, 32'h1111_1111, 1'b0, 1'b1);
    tick();
    drive_push(32'h20, 32'h2222_2222, 1'b0, 1'b1);
    tick();
    push_valid = 1'b0;
    lookup_addr = 32'h22;
    #1;
`ifdef STORE_FWD_EN
    chk("fwd_hit", 65'(lookup_hit), 65'd1);
    chk("fwd_data", 65'(lookup_data), 65'h2222_2222);
    chk("fwd_conf", 65'(lookup_conflict), 65'd0);
`else
    chk("nofwd_hit", 65'(lookup_hit), 65'd0);
    chk("nofwd_data", 65'(lookup_data), 65'd0);
    chk("nofwd_conf", 65'(lookup_conflict), 65'd1);
`endif
    lookup_addr = 32'h24;
    #1;
    chk("miss_hit", 65'(lookup_hit), 65'd0);
    chk("miss_conf", 65'(lookup_conflict), 65'd0);
    drive_push(32'h31, 32'hAB, 1'b1, 1'b1);
    tick();
    push_valid = 1'b0;
    lookup_addr = 32'h30;
    #1;
    chk("byte_conf", 65'(lookup_conflict), 65'd1);
    chk("byte_hit", 65'(lookup_hit), 65'd0);
    chk("byte_count", 65'(count), 65'd3);

    // Reset while draining
    mem_busy = 1'b0;
    #1;
    chk("pre_rst_we", 65'(mem_we), 65'd1);
    tick();
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_we", 65'(mem_we), 65'd0);
    chk("mid_rst_count", 65'(count), 65'd0);
    chk("mid_rst_conf", 65'(lookup_conflict), 65'd0);
    tick();
    rst = 1'b0;
    tick();
    check_idle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_drain_buffer.md
# store_drain_buffer

Posted-write buffer between the pipeline's memory stage and the data memory / cache pair. Accepts store requests at one per cycle and queues them in a small FIFO. Drains them to the data memory write port whenever the memory is not busy with a miss refill read. Loads probe the buffer so they never observe stale memory: they either get forwarded data or a stall request.

## Interface
Parameters:
- DATA_WIDTH, 32, width of address and data.
- DEPTH, 4, number of buffered stores; power of two, at least 2.

Ports:
- clk  input  1  single clock, all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- push_valid  input  1  store request from the pipeline.
- push_addr  input  DATA_WIDTH  store byte address.
- push_data  input  DATA_WIDTH  store data; byte stores use bits [7:0].
- push_byte  input  1  1 = byte store, 0 = word store.
- push_ready  output  1  buffer can accept; equals not full.
- mem_busy  input  1  memory is performing a refill read (REN); blocks draining.
- mem_we  output  1  write enable to data memory WE.
- mem_addr  output  DATA_WIDTH  head entry address.
- mem_wd  output  DATA_WIDTH  head entry data.
- mem_byte  output  1  head entry byte flag, drives memory ByteAddr.
- lookup_addr  input  DATA_WIDTH  address of the load in the memory stage.
- lookup_hit  output  1  load is satisfied from the buffer.
- lookup_data  output  DATA_WIDTH  forwarded word; 0 when lookup_hit = 0.
- lookup_conflict  output  1  load must stall until the buffer drains the matching entry.
- empty  output  1  no entries held.
- count  output  $clog2(DEPTH)+1  number of entries held.

## Operation
- Storage: DEPTH entries of {addr, data, byte}, circular, with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- Push: when push_valid && push_ready at an edge, write to the tail, advance the tail, and increment count. When push_ready = 0, the request is ignored and the source must hold it.
- Drain: mem_we = !empty && !mem_busy. mem_addr, mem_wd and mem_byte come combinationally from the head. When mem_we = 1 at an edge, advance the head and decrement count.
- Simultaneous push and drain: count is unchanged and both pointers advance.
- push_ready reflects the state before the edge. A full buffer rejects a push even in a cycle that drains; there is no pass-through.
- An empty buffer never bypasses: a store pushed into an empty buffer writes memory no earlier than the next cycle.
- Drain order is strictly FIFO.
- Address match rule: entry word address (addr[DATA_WIDTH-1:2]) equals lookup_addr[DATA_WIDTH-1:2]. All valid entries are compared, including the head being drained this cycle.

## Timing
- Reset (async assert): pointers = 0 and count = 0, and all entries are cleared to 0. Outputs: empty = 1, push_ready = 1, mem_we = 0, mem_addr = 0, mem_wd = 0, mem_byte = 0, lookup_hit = 0, lookup_data = 0, lookup_conflict = 0.
- Reset mid-operation discards all pending stores. Reset release takes effect at the next edge.
- Latency: a store accepted at edge N gives mem_we = 1 in cycle N+1 if mem_busy = 0, and the memory write occurs at edge N+1.
- mem_busy high holds mem_we low and keeps the head stable for as many cycles as mem_busy is high.
- Throughput: one push and one drain per cycle.
- Lookup outputs are purely combinational from the current contents and lookup_addr.

## Configuration
- STORE_FWD_EN defined:
  - If the youngest matching entry is a word store, assert lookup_hit = 1 with lookup_data = that entry's data, and hold lookup_conflict = 0.
  - If the youngest matching entry is a byte store, assert lookup_conflict = 1 and hold lookup_hit = 0.
- STORE_FWD_EN undefined: lookup_hit and lookup_data are tied to 0, and lookup_conflict = 1 on any match.

## Test plan
- Reset then idle: empty = 1, push_ready = 1, count = 0, mem_we = 0 on every cycle.
- Word store 0x0000_0010 / 0xDEAD_BEEF, mem_busy = 0: mem_we = 1 exactly one cycle later with mem_addr = 0x10 and mem_wd = 0xDEADBEEF, then empty = 1.
- Fill with DEPTH = 4 stores while mem_busy = 1: push_ready = 0 and count = 4, and a fifth push is ignored. Release mem_busy: 4 writes occur in push order on consecutive cycles, then the pointers wrap and a new push drains correctly.
- Full buffer with push_valid held and mem_busy = 0: at the first edge the head drains and the push is rejected; at the next edge the push is accepted.
- Word stores 0x20/0x1111_1111 then 0x20/0x2222_2222, lookup_addr = 0x22:
  - With STORE_FWD_EN: lookup_hit = 1, lookup_data = 0x22222222.
  - Without STORE_FWD_EN: lookup_conflict = 1, lookup_hit = 0.
- Byte store 0x31/0xAB with lookup_addr = 0x30: lookup_conflict = 1, lookup_hit = 0 in both configurations. Assert rst mid-drain: mem_we drops to 0 immediately and count = 0.
